// File: rtl/muldiv_sequencer_if.sv
// Handshake/bus bundle between control and the multiply/divide sequencer.
// Ports: start/op/a/b request, hi_we/lo_we/wdata moves, abort; busy/done/hi/lo back.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_hi_we;
    logic             i_lo_we;
    logic [WIDTH-1:0] i_wdata;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b,
        output i_hi_we, i_lo_we, i_wdata, i_abort,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        input  i_hi_we, i_lo_we, i_wdata, i_abort,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle.
// Ports: i_clk, i_reset (async, active-high), bus (muldiv_sequencer_if.slave).
// Optional: define MULDIV_ABORT_EN to let abort cancel an op in RUN/FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    muldiv_sequencer_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_m;
    logic [CW-1:0]  r_cnt;
    logic           r_div;
    logic           r_sa;
    logic           r_sb;
    logic           r_done;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_abort;
    logic           w_signed;
    logic           w_isdiv;
    logic           w_dz;
    logic [W-1:0]   w_ma;
    logic [W-1:0]   w_mb;
    logic [W:0]     w_sum;
    logic [W:0]     w_rsh;
    logic           w_ge;
    logic [W-1:0]   w_rem_n;
    logic [2*W-1:0] w_step;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_q;
    logic [W-1:0]   w_r;

`ifdef MULDIV_ABORT_EN
    assign w_abort = bus.i_abort;
`else
    // Port kept for a uniform interface; it never affects behaviour.
    assign w_abort = 1'b0 & bus.i_abort;
`endif

    // op[1]: divide, op[0]: unsigned
    assign w_isdiv  = bus.i_op[1];
    assign w_signed = ~bus.i_op[0];
    assign w_dz     = w_isdiv && (bus.i_b == '0);
    assign w_ma = (w_signed && bus.i_a[W-1]) ? -bus.i_a : bus.i_a;
    assign w_mb = (w_signed && bus.i_b[W-1]) ? -bus.i_b : bus.i_b;

    // One iteration. Multiply keeps the multiplier in the low half and
    // shifts the carry-extended partial sum in from the top. Divide shifts
    // the dividend into the remainder half and the quotient bit into bit 0.
    always_comb begin
        w_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_m};
        w_rsh   = {r_acc[2*W-1:W], r_acc[W-1]};
        w_ge    = (w_rsh >= {1'b0, r_m});
        w_rem_n = w_ge ? W'(w_rsh - {1'b0, r_m}) : w_rsh[W-1:0];
        if (r_div)
            w_step = {w_rem_n, r_acc[W-2:0], w_ge};
        else if (r_acc[0])
            w_step = {w_sum, r_acc[W-1:1]};
        else
            w_step = {1'b0, r_acc[2*W-1:1]};
    end

    // Sign fix-up; flags are zero for unsigned ops and divide-by-zero.
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_q    = (r_sa ^ r_sb) ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_r    = r_sa ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (bus.i_start)
                    w_next = w_dz ? S_FIX : S_RUN;
            S_RUN:
                if (w_abort)
                    w_next = S_IDLE;
                else if (r_cnt == '0)
                    w_next = S_FIX;
            S_FIX:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_hi_we)
                        r_hi <= bus.i_wdata;
                    if (bus.i_lo_we)
                        r_lo <= bus.i_wdata;
                    if (bus.i_start) begin
                        r_div <= w_isdiv;
                        r_cnt <= CW'(W - 1);
                        r_m   <= w_isdiv ? w_mb : w_ma;
                        if (w_dz) begin
                            // FIX then emits hi=a, lo=all ones unchanged
                            r_acc <= {bus.i_a, {W{1'b1}}};
                            r_sa  <= 1'b0;
                            r_sb  <= 1'b0;
                        end else begin
                            r_acc <= {{W{1'b0}}, w_isdiv ? w_ma : w_mb};
                            r_sa  <= w_signed & bus.i_a[W-1];
                            r_sb  <= w_signed & bus.i_b[W-1];
                        end
                    end
                end
                S_RUN:
                    if (!w_abort) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                    end
                S_FIX:
                    if (!w_abort) begin
                        r_done <= 1'b1;
                        if (r_div) begin
                            r_hi <= w_r;
                            r_lo <= w_q;
                        end else begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end
                    end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_busy = (r_state != S_IDLE);
        bus.o_done = r_done;
        bus.o_hi   = r_hi;
        bus.o_lo   = r_lo;
    end
endmodule
